fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline. Owns the PC and drives the word

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_pc_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants: bus width, reset PC, bubble encoding, memory depth.
// The same values are used by the instruction memory.
package fetch_stage_pkg;
    localparam int          DATA_W         = 32;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0000;
    localparam int          IMEM_WORDS_DEF = 128;
    localparam logic [31:0] CNT_MAX        = 32'hFFFF_FFFF;

    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
        return {a[DATA_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with next-PC selection: branch > jump > stall > sequential.
// Redirect targets are word-aligned before they are loaded.
module fetch_stage_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [DATA_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [DATA_W-1:0] jump_target_i,
    output logic [DATA_W-1:0] pc_o
);
    logic [DATA_W-1:0] pc_d;
    logic [DATA_W-1:0] pc_q;

    // A redirect wins over a stall so a resolved branch or jump is never dropped.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (branch_taken_i) begin
            pc_d = word_align(branch_target_i);
        end else if (jump_i) begin
            pc_d = word_align(jump_target_i);
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= word_align(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: drives the PC to the combinational instruction memory and registers
// {instruction, PC+4, valid} into IF/ID, with stall, flush and redirect handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF,
    parameter int          IMEM_WORDS = IMEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              branch_taken_i,
    input  logic [DATA_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [DATA_W-1:0] jump_target_i,
    output logic [DATA_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic [DATA_W-1:0] ifid_instr_o,
    output logic [DATA_W-1:0] ifid_pc4_o,
    output logic              ifid_valid_o,
    output logic [DATA_W-1:0] fetch_cnt_o
);
    logic [DATA_W-1:0] pc;
    logic              redirect;

    logic [DATA_W-1:0] ifid_instr_d, ifid_instr_q;
    logic [DATA_W-1:0] ifid_pc4_d, ifid_pc4_q;
    logic              ifid_valid_d, ifid_valid_q;
    logic [DATA_W-1:0] fetch_cnt_d, fetch_cnt_q;

    if (IMEM_WORDS < 1) begin : g_bad_depth
        $error("fetch_stage: IMEM_WORDS must be at least 1");
    end

    fetch_stage_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .pc_o           (pc)
    );

    // Memory wraps the word index itself; the address is the raw PC.
    assign imem_addr_o = pc;
    assign redirect    = flush_i | branch_taken_i | jump_i;

    // Any redirect squashes the wrong-path word, even during a stall.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        if (redirect) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = '0;
            ifid_valid_d = 1'b0;
        end else if (!stall_i) begin
            ifid_instr_d = imem_data_i;
            ifid_pc4_d   = pc + 32'd4;
            ifid_valid_d = 1'b1;
            if (fetch_cnt_q != CNT_MAX) begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign ifid_instr_o = ifid_instr_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_valid_o = ifid_valid_q;
    assign fetch_cnt_o  = fetch_cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed hazard scenarios plus random hazards,
// checked against a cycle-level model of the fetch rules.
module tb_fetch_stage;
    localparam int          WORDS = 128;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, br, jp;
    logic [31:0] bt, jt;
    logic [31:0] imem_addr, imem_data, ifid_instr, ifid_pc4, fetch_cnt;
    logic        ifid_valid;

    logic [31:0] mem [WORDS];

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    always #5 clk = ~clk;

    assign imem_data = mem[(imem_addr >> 2) % WORDS];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall),
        .flush_i        (flush),
        .branch_taken_i (br),
        .branch_target_i(bt),
        .jump_i         (jp),
        .jump_target_i  (jt),
        .imem_addr_o    (imem_addr),
        .imem_data_i    (imem_data),
        .ifid_instr_o   (ifid_instr),
        .ifid_pc4_o     (ifid_pc4),
        .ifid_valid_o   (ifid_valid),
        .fetch_cnt_o    (fetch_cnt)
    );

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; br = 0; jp = 0; bt = 32'h0; jt = 32'h0;
    endtask

    // One clock edge: the model's next state comes from the rules applied to the
    // inputs present before the edge; comparisons happen 1 ns after it.
    task automatic step();
        logic [31:0] n_pc, n_instr, n_pc4, n_cnt;
        logic        n_valid;
        n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid; n_cnt = m_cnt;
        if (flush || br || jp) begin
            n_instr = NOP; n_pc4 = 32'h0; n_valid = 1'b0;
        end else if (!stall) begin
            n_instr = mem[(m_pc / 4) % WORDS];
            n_pc4   = m_pc + 4;
            n_valid = 1'b1;
            n_cnt   = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
        end
        if (br)         n_pc = bt & ~32'h3;
        else if (jp)    n_pc = jt & ~32'h3;
        else if (stall) n_pc = m_pc;
        else            n_pc = m_pc + 4;
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid; m_cnt = n_cnt;
    endtask

    task automatic test_reset();
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
        total++; if (ifid_instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", ifid_instr, NOP); end
        total++; if (ifid_pc4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", ifid_pc4); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
        total++; if (fetch_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", fetch_cnt); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 2; i++) begin
            step();
            total++; if (imem_addr !== 32'(4 * i)) begin bad++; $display("FAIL seq_addr got=%h exp=%h", imem_addr, 32'(4 * i)); end
            total++; if (ifid_pc4 !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc4 got=%h exp=%h", ifid_pc4, 32'(4 * i)); end
            total++; if (ifid_instr !== mem[i - 1]) begin bad++; $display("FAIL seq_instr got=%h exp=%h", ifid_instr, mem[i - 1]); end
            total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%b exp=1", ifid_valid); end
        end
    endtask

    task automatic test_stall();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL stall_addr got=%h exp=8", imem_addr); end
            total++; if (ifid_pc4 !== 32'h8 || ifid_instr !== mem[1]) begin bad++; $display("FAIL stall_hold got=%h/%h exp=%h/%h", ifid_instr, ifid_pc4, mem[1], 32'h8); end
            total++; if (fetch_cnt !== 32'd2) begin bad++; $display("FAIL stall_cnt got=%0d exp=2", fetch_cnt); end
        end
        stall = 0;
        step();
        total++; if (imem_addr !== 32'hC || ifid_instr !== mem[2]) begin bad++; $display("FAIL unstall got=%h/%h exp=%h/%h", imem_addr, ifid_instr, 32'hC, mem[2]); end
    endtask

    task automatic test_jump();
        jp = 1; jt = 32'h20;
        step();
        jp = 0;
        total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL jump_addr got=%h exp=20", imem_addr); end
        total++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin bad++; $display("FAIL jump_bubble got=%b/%h exp=0/%h", ifid_valid, ifid_instr, NOP); end
        step();
        total++; if (ifid_instr !== mem[8] || ifid_pc4 !== 32'h24) begin bad++; $display("FAIL jump_target got=%h/%h exp=%h/24", ifid_instr, ifid_pc4, mem[8]); end
    endtask

    task automatic test_branch_priority();
        br = 1; bt = 32'h40; jp = 1; jt = 32'h80; stall = 1;
        step();
        clear_inputs();
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL prio_addr got=%h exp=40", imem_addr); end
        total++; if (ifid_valid !== 1'b0 || ifid_pc4 !== 32'h0) begin bad++; $display("FAIL prio_bubble got=%b/%h exp=0/0", ifid_valid, ifid_pc4); end
        step();
        total++; if (ifid_instr !== mem[16] || ifid_valid !== 1'b1) begin bad++; $display("FAIL prio_next got=%h/%b exp=%h/1", ifid_instr, ifid_valid, mem[16]); end
    endtask

    task automatic test_wrap();
        jp = 1; jt = 32'h1FC;
        step();
        jp = 0;
        step();
        total++; if (imem_addr !== 32'h200 || ifid_instr !== mem[WORDS - 1]) begin bad++; $display("FAIL wrap_last got=%h/%h exp=200/%h", imem_addr, ifid_instr, mem[WORDS - 1]); end
        step();
        total++; if (ifid_instr !== mem[0] || ifid_pc4 !== 32'h204) begin bad++; $display("FAIL wrap_index got=%h/%h exp=%h/204", ifid_instr, ifid_pc4, mem[0]); end
        jp = 1; jt = 32'hFFFF_FFFE;
        step();
        jp = 0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL align_addr got=%h exp=fffffffc", imem_addr); end
        step();
        total++; if (imem_addr !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1) begin bad++; $display("FAIL pc32_wrap got=%h/%h/%b exp=0/0/1", imem_addr, ifid_pc4, ifid_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            br    = ($urandom_range(0, 9) == 0);
            jp    = ($urandom_range(0, 9) == 0);
            bt    = $urandom();
            jt    = $urandom_range(0, 1023);
            step();
            total++;
            if (imem_addr !== m_pc || ifid_instr !== m_instr || ifid_pc4 !== m_pc4 ||
                ifid_valid !== m_valid || fetch_cnt !== m_cnt) begin
                bad++;
                $display("FAIL rand_%0d got=%h/%h/%h/%b/%0d exp=%h/%h/%h/%b/%0d", i,
                         imem_addr, ifid_instr, ifid_pc4, ifid_valid, fetch_cnt,
                         m_pc, m_instr, m_pc4, m_valid, m_cnt);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        jp = 1; jt = 32'h100;
        #2 rst = 0;
        #1;
        model_reset();
        total++; if (imem_addr !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== NOP) begin bad++; $display("FAIL mid_reset got=%h/%b/%h exp=0/0/%h", imem_addr, ifid_valid, ifid_instr, NOP); end
        total++; if (fetch_cnt !== 32'h0 || ifid_pc4 !== 32'h0) begin bad++; $display("FAIL mid_reset_cnt got=%h/%h exp=0/0", fetch_cnt, ifid_pc4); end
        jp = 0;
        #2 rst = 1;
        step();
        total++; if (imem_addr !== 32'h4 || ifid_instr !== mem[0] || fetch_cnt !== 32'd1) begin bad++; $display("FAIL restart got=%h/%h/%0d exp=4/%h/1", imem_addr, ifid_instr, fetch_cnt, mem[0]); end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom() ^ (32'(i) << 24) ^ 32'(i + 1);
        rst = 0;
        clear_inputs();
        model_reset();
        #12;
        test_reset();
        rst = 1;
        test_sequential();
        test_stall();
        test_jump();
        test_branch_priority();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
